// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipeline hazard unit
package pipe_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        MULT_IDLE = 1'b0,
        MULT_BUSY = 1'b1
    } mult_state_t;

endpackage

// File: rtl/mult_interlock.sv
// rtl/mult_interlock.sv - tracks multiplier occupancy after a multiply issues
module mult_interlock
    import pipe_pkg::*;
#(
    parameter int MULT_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    output logic mult_busy
);

    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    mult_state_t   state;
    logic [CW-1:0] cnt;

    // cnt holds the busy cycles still to come after the current one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MULT_IDLE;
            cnt       <= '0;
            mult_busy <= 1'b0;
        end else begin
            case (state)
                MULT_IDLE: begin
                    if (issue) begin
                        state     <= MULT_BUSY;
                        cnt       <= CW'(MULT_LAT - 1);
                        mult_busy <= 1'b1;
                    end
                end
                MULT_BUSY: begin
                    if (cnt == '0) begin
                        state     <= MULT_IDLE;
                        mult_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= MULT_IDLE;
                    mult_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall, flush and forwarding control for the 5-stage pipeline
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 16,
    parameter int FWD_EN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemToRegE,
    input  logic              MemToRegM,
    input  logic              BranchD,
    input  logic              multiply,
    input  logic              HiLoReadD,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic              mult_busy,
    output logic [CNT_W-1:0]  stall_count
);

    // r0 is hardwired zero, so it never creates a dependency
    function automatic logic dep(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] dst,
                                 input logic              we);
        return we && (src != '0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (dep(src, WriteRegM, RegWriteM))
            return FWD_M;
        else if (dep(src, WriteRegW, RegWriteW))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    logic lwstall, brstall, rawstall, multstall;
    logic dep_stall, stall, mult_issue;

    assign lwstall  = MemToRegE && (dep(RsD, WriteRegE, 1'b1) || dep(RtD, WriteRegE, 1'b1));
    assign brstall  = BranchD &&
                      (dep(RsD, WriteRegE, RegWriteE) || dep(RtD, WriteRegE, RegWriteE) ||
                       dep(RsD, WriteRegM, MemToRegM) || dep(RtD, WriteRegM, MemToRegM));
    assign rawstall = dep(RsD, WriteRegE, RegWriteE) || dep(RtD, WriteRegE, RegWriteE) ||
                      dep(RsD, WriteRegM, RegWriteM) || dep(RtD, WriteRegM, RegWriteM) ||
                      dep(RsD, WriteRegW, RegWriteW) || dep(RtD, WriteRegW, RegWriteW);

    assign dep_stall  = (FWD_EN != 0) ? (lwstall || brstall) : rawstall;
    assign multstall  = mult_busy && (multiply || HiLoReadD);
    assign stall      = dep_stall || multstall;
    assign mult_issue = multiply && !dep_stall;

    mult_interlock #(
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .clk       (clk),
        .rst_n     (reset),
        .issue     (mult_issue),
        .mult_busy (mult_busy)
    );

    // while reset is held the ID-EX register is flushed and nothing is stalled
    assign StallF    = reset && stall;
    assign StallD    = reset && stall;
    assign FlushE    = !reset || stall;
    assign ForwardAE = (FWD_EN != 0 && reset) ? fwd_sel(RsE) : FWD_RF;
    assign ForwardBE = (FWD_EN != 0 && reset) ? fwd_sel(RtE) : FWD_RF;
    assign ForwardAD = (FWD_EN != 0) && reset && dep(RsD, WriteRegM, RegWriteM);
    assign ForwardBD = (FWD_EN != 0) && reset && dep(RtD, WriteRegM, RegWriteM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (StallD && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule
